// File: rtl/mux_rr4_pkg.sv
// mux_rr4_pkg: shared constants for the four-lane round-robin byte merger.
//   DATA_W_DEF - default byte-lane width
//   DEPTH_DEF  - default per-lane FIFO depth (power of 2, >= 2)
//   NUM_LANES  - number of input lanes
//   LANE_W     - width of a lane index
package mux_rr4_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int NUM_LANES  = 4;
    localparam int LANE_W     = 2;

endpackage

// File: rtl/mux_rr4_fifo_lane.sv
// fifo_lane: single-clock FIFO for one input lane.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (clears pointers and count)
//   push  - write din; ignored while full (a full lane refuses even if popped)
//   pop   - remove the head; ignored while empty
//   din   - write data
//   dout  - current head entry (valid when count != 0)
//   count - number of stored entries, 0..DEPTH
//   full  - count == DEPTH
module fifo_lane
    import mux_rr4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Full uses the pre-edge count, so a same-cycle pop never frees room for a push.
    assign full      = (count_r == CNT_W'(DEPTH));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/mux_rr4.sv
// mux_rr4: merges four byte lanes into one stream with round-robin arbitration.
//   clk                         - rising-edge clock
//   reset                       - asynchronous active-low reset
//   Entrada0..3 / validEntrada0..3 - lane bytes and their valids
//   full0..3                    - lane FIFO full (pushes refused)
//   Salida / validSalida / laneSalida - registered output byte, valid, source lane
//   readySalida                 - downstream accepts Salida
//   overflow                    - sticky per-lane flag for dropped pushes
module mux_rr4
    import mux_rr4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    Entrada0,
    input  logic [DATA_W-1:0]    Entrada1,
    input  logic [DATA_W-1:0]    Entrada2,
    input  logic [DATA_W-1:0]    Entrada3,
    input  logic                 validEntrada0,
    input  logic                 validEntrada1,
    input  logic                 validEntrada2,
    input  logic                 validEntrada3,
    output logic                 full0,
    output logic                 full1,
    output logic                 full2,
    output logic                 full3,
    output logic [DATA_W-1:0]    Salida,
    output logic                 validSalida,
    output logic [LANE_W-1:0]    laneSalida,
    input  logic                 readySalida,
    output logic [NUM_LANES-1:0] overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]    din_s    [NUM_LANES];
    logic [DATA_W-1:0]    dout_s   [NUM_LANES];
    logic [CNT_W-1:0]     count_s  [NUM_LANES];
    logic [NUM_LANES-1:0] vin_s;
    logic [NUM_LANES-1:0] full_s;
    logic [NUM_LANES-1:0] nonempty_s;
    logic [NUM_LANES-1:0] pop_s;

    logic                 slot_free_s;
    logic                 grant_found_s;
    logic [LANE_W-1:0]    grant_idx_s;

    logic [DATA_W-1:0]    salida_r;
    logic [LANE_W-1:0]    lane_r;
    logic                 valid_r;
    logic [LANE_W-1:0]    ptr_r;
    logic [NUM_LANES-1:0] overflow_r;

    assign din_s[0] = Entrada0;
    assign din_s[1] = Entrada1;
    assign din_s[2] = Entrada2;
    assign din_s[3] = Entrada3;
    assign vin_s    = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign nonempty_s[i] = (count_s[i] != {CNT_W{1'b0}});
        assign pop_s[i]      = slot_free_s & grant_found_s & (grant_idx_s == LANE_W'(i));

        fifo_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (vin_s[i]),
            .pop   (pop_s[i]),
            .din   (din_s[i]),
            .dout  (dout_s[i]),
            .count (count_s[i]),
            .full  (full_s[i])
        );
    end

    // The output slot can be reloaded when empty or being drained this edge.
    assign slot_free_s = ~valid_r | readySalida;

    // Round-robin scan starting at ptr; first non-empty lane (pre-edge counts) wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = ptr_r;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!grant_found_s && nonempty_s[ptr_r + LANE_W'(k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ptr_r + LANE_W'(k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Output register and round-robin pointer; held while a byte waits for ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            salida_r <= {DATA_W{1'b0}};
            lane_r   <= {LANE_W{1'b0}};
            valid_r  <= 1'b0;
            ptr_r    <= {LANE_W{1'b0}};
        end else if (slot_free_s) begin
            if (grant_found_s) begin
                salida_r <= dout_s[grant_idx_s];
                lane_r   <= grant_idx_s;
                valid_r  <= 1'b1;
                ptr_r    <= grant_idx_s + LANE_W'(1);
            end else begin
                valid_r  <= 1'b0;
            end
        end
    end

    // Sticky drop flags: set by a push attempted against a full lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= {NUM_LANES{1'b0}};
        end else begin
            overflow_r <= overflow_r | (vin_s & full_s);
        end
    end

    assign Salida      = salida_r;
    assign laneSalida  = lane_r;
    assign validSalida = valid_r;
    assign overflow    = overflow_r;
    assign full0       = full_s[0];
    assign full1       = full_s[1];
    assign full2       = full_s[2];
    assign full3       = full_s[3];

endmodule

// File: tb/tb_mux_rr4.sv
module tb_mux_rr4;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din [4];
    logic [3:0] vin = 4'b0000;
    logic       ready = 1'b0;

    logic       full0, full1, full2, full3;
    logic [7:0] Salida;
    logic       validSalida;
    logic [1:0] laneSalida;
    logic [3:0] overflow;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: one queue per lane plus the output slot.
    logic [7:0] mq [4][$];
    bit         m_valid;
    logic [7:0] m_data;
    int         m_lane;
    int         m_ptr;
    logic [3:0] m_ovf;

    mux_rr4 #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .Entrada0(din[0]), .Entrada1(din[1]), .Entrada2(din[2]), .Entrada3(din[3]),
        .validEntrada0(vin[0]), .validEntrada1(vin[1]),
        .validEntrada2(vin[2]), .validEntrada3(vin[3]),
        .full0(full0), .full1(full1), .full2(full2), .full3(full3),
        .Salida(Salida), .validSalida(validSalida), .laneSalida(laneSalida),
        .readySalida(ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] m_full();
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = (mq[i].size() == DEPTH);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_valid = 1'b0; m_data = 8'h00; m_lane = 0; m_ptr = 0; m_ovf = 4'b0000;
    endtask

    // One clock edge of the specified behaviour, using pre-edge occupancy.
    task automatic model_edge();
        bit pre_full [4];
        bit pre_ne [4];
        int g;
        for (int i = 0; i < 4; i++) begin
            pre_full[i] = (mq[i].size() == DEPTH);
            pre_ne[i]   = (mq[i].size() > 0);
        end
        if (!m_valid || ready) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && pre_ne[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
            if (g >= 0) begin
                m_data = mq[g].pop_front();
                m_lane = g;
                m_valid = 1'b1;
                m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (vin[i]) begin
                if (pre_full[i]) m_ovf[i] = 1'b1;
                else mq[i].push_back(din[i]);
            end
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("validSalida", validSalida, m_valid);
            if (m_valid) begin
                check("Salida", Salida, m_data);
                check("laneSalida", laneSalida, m_lane);
            end
            check("full", {full3, full2, full1, full0}, m_full());
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic cycle();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic apply_reset();
        vin = 4'b0000; ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_valid", validSalida, 1'b0);
        check("rst_salida", Salida, 8'h00);
        check("rst_lane", laneSalida, 2'd0);
        check("rst_full", {full3, full2, full1, full0}, 4'b0000);
        check("rst_ovf", overflow, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        #2;
        apply_reset();
        cmp_en = 1'b1;

        // Single byte on lane 2
        ready = 1'b1; vin = 4'b0100; din[2] = 8'hA5;
        cycle();
        check("t38_v0", validSalida, 1'b0);
        vin = 4'b0000;
        cycle();
        check("t38_data", Salida, 8'hA5);
        check("t38_lane", laneSalida, 2'd2);
        check("t38_v1", validSalida, 1'b1);
        cycle();
        check("t38_v2", validSalida, 1'b0);

        // All four lanes at once, then pointer wrap
        apply_reset();
        ready = 1'b1; vin = 4'b1111;
        din[0] = 8'h10; din[1] = 8'h20; din[2] = 8'h30; din[3] = 8'h40;
        cycle();
        vin = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t39_data", Salida, 8'h10 * (k + 1));
            check("t39_lane", laneSalida, k);
        end
        vin = 4'b0011; din[0] = 8'h77; din[1] = 8'h88;
        cycle();
        vin = 4'b0000;
        cycle();
        check("t39_wrap_lane", laneSalida, 2'd0);
        check("t39_wrap_data", Salida, 8'h77);
        cycle();
        check("t39_next_lane", laneSalida, 2'd1);

        // Lane 1 filled against a stalled output: one byte sits in the slot
        apply_reset();
        ready = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            vin = 4'b0010; din[1] = n;
            cycle();
            if (n == 4) check("t40_notfull", full1, 1'b0);
            if (n == 5) begin
                check("t40_full", full1, 1'b1);
                check("t40_ovf0", overflow, 4'b0000);
            end
        end
        check("t40_ovf", overflow, 4'b0010);
        vin = 4'b0000;
        check("t40_hold", Salida, 8'd1);
        ready = 1'b1;
        for (int r = 2; r <= 5; r++) begin
            cycle();
            check("t40_order", Salida, r);
        end
        cycle();
        check("t40_drain", validSalida, 1'b0);
        check("t40_sticky", overflow, 4'b0010);

        // Back-pressure holds the slot stable
        apply_reset();
        ready = 1'b0; vin = 4'b0001; din[0] = 8'h55;
        cycle();
        din[0] = 8'h66;
        cycle();
        vin = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t41_data", Salida, 8'h55);
            check("t41_lane", laneSalida, 2'd0);
            check("t41_valid", validSalida, 1'b1);
        end
        ready = 1'b1;
        cycle();
        check("t41_next", Salida, 8'h66);

        // Lanes 0 and 3 continuously fed alternate
        apply_reset();
        ready = 1'b1; vin = 4'b1001;
        for (int k = 1; k <= 12; k++) begin
            din[0] = 8'h00 + k; din[3] = 8'h80 + k;
            cycle();
            if (k >= 2) check("t42_lane", laneSalida, (k % 2 == 0) ? 2'd0 : 2'd3);
        end

        // Random traffic
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                vin[i] = ($urandom_range(0, 99) < 40);
                din[i] = $urandom_range(0, 255);
            end
            ready = ($urandom_range(0, 99) < 65);
            cycle();
        end

        // Reset asserted between edges mid-stream
        ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vin = 4'b1111;
            for (int i = 0; i < 4; i++) din[i] = $urandom_range(0, 255);
            cycle();
        end
        #2;
        reset = 1'b0;
        model_reset();
        vin = 4'b0000;
        #1;
        check("t43_valid", validSalida, 1'b0);
        check("t43_full", {full3, full2, full1, full0}, 4'b0000);
        check("t43_ovf", overflow, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t43_nostale", validSalida, 1'b0);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
